load_store_arbiter: RTL and testbench
=====================================

LOAD_STORE_ARBITER -- requirements
Module: load_store_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rstN  in  1  asynchronous active-low reset.
REQ-002 reqEnable  in  2  per-requester request valid (bit 0 = execute stage, bit 1 = secondary requester); the requester holds it high until its reqDone.
REQ-003 req  in  2 x LsuRequest  per-requester request payload, stable while reqEnable is high.
REQ-004 reqDone  out  2  one-cycle completion pulse to the owning requester.
REQ-005 respResult  out  64  completed access result, valid when any reqDone bit is high.
REQ-006 respLoadPagefault / respStorePagefault  out  1 each  fault flags, valid with reqDone.
REQ-007 lsuEnable  out  1  request to the shared load/store unit.
REQ-008 lsuRequest  out  LsuRequest  payload to the unit: addr, command, loadStoreUnitCommand, imm, srcIntRegValue1/2, srcFpRegValue2, invalidateTlb.
REQ-009 lsuDone, lsuResult (64), lsuLoadPagefault, lsuStorePagefault  in  unit completion and response.
REQ-010 busy  out  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-012 IDLE: when any reqEnable bit is high, the arbiter SHALL select a winner, copy its payload into a holding register, record the owner, and enter BUSY on the next edge.
REQ-013 Selection SHALL be round-robin: a 1-bit priority pointer names the preferred requester; when only one requester is requesting, that requester wins regardless of the pointer.
REQ-014 BUSY: lsuEnable SHALL be 1 and lsuRequest SHALL equal the holding register, unchanged until lsuDone.
REQ-015 When lsuDone=1 in BUSY, the block SHALL latch lsuResult and both fault flags, and enter RESP.
REQ-016 RESP: reqDone[owner] SHALL be 1 for exactly one cycle with the latched response, lsuEnable SHALL be 0, and the pointer SHALL be set to the non-owner; the FSM then returns to IDLE.
REQ-017 Latency: a request first seen at IDLE edge T SHALL give lsuEnable=1 in T+1; lsuDone in cycle D SHALL give reqDone in D+1, and IDLE in D+2.
REQ-018 A reqEnable still high in the IDLE cycle after reqDone SHALL be treated as a new request.
REQ-019 A requester dropping reqEnable while BUSY SHALL NOT abort the access; its reqDone still pulses once.
REQ-020 The non-owner's reqEnable SHALL be ignored while in BUSY or RESP; it waits and wins next by the pointer.
REQ-021 lsuDone outside BUSY SHALL be ignored.
REQ-022 In IDLE, lsuRequest SHALL be driven to the holding register contents, and lsuEnable SHALL be 0.
REQ-023 Both reqDone bits SHALL never be high at the same time.

Reset
REQ-024 While rstN=0, the block SHALL be in IDLE with the following values: pointer=0, owner=0, holding register all-zero, reqDone=00, lsuEnable=0, busy=0, respResult=0, and both fault flags 0.
REQ-025 Reset asserted in BUSY or RESP SHALL discard the in-flight access with no reqDone pulse.

Structure
REQ-026 The shared package SHALL hold the LsuRequest packed struct (addr_t, MemUnitCommand, LoadStoreUnitCommand, word_t imm/src1/src2, uint64_t fp src2, invalidateTlb), the FSM state enum, and the requester-count constant (2).
REQ-027 The block SHALL contain one sub-module, load_store_arbiter_select: a combinational round-robin picker (inputs: request vector, pointer; outputs: grant valid, grant index).

Verification
REQ-028 Single requester: reqEnable=01, addr=0x1000, LSU done 3 cycles after lsuEnable, lsuResult=0xDEADBEEF -> lsuEnable high 3 cycles; reqDone=01 one cycle later with respResult=0xDEADBEEF.
REQ-029 Contention: reqEnable=11 from reset -> req0 served first, then req1; pointer=1 after the first completion and 0 after the second.
REQ-030 Fairness: reqEnable held at 11 for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-031 Fault: requester 1 store, lsuStorePagefault=1 with lsuDone -> reqDone=10 with respStorePagefault=1 and respLoadPagefault=0.
REQ-032 Disturbance: requester 0 drops reqEnable mid-BUSY, and lsuDone is pulsed while IDLE -> access completes with a single reqDone=01, and the stray lsuDone causes no state change.
REQ-033 Reset mid-BUSY: assert rstN=0 asynchronously -> all outputs go to their reset values immediately, and no reqDone is seen after release.

Source files
------------

// File: rtl/load_store_arbiter_pkg.sv
// Shared types for the load/store arbiter: LSU request payload, command
// encodings, arbiter FSM states and requester count.
package load_store_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned XLEN    = 64;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [63:0]     uint64_t;

  typedef enum logic [1:0] {
    MEM_CMD_LOAD  = 2'd0,
    MEM_CMD_STORE = 2'd1,
    MEM_CMD_FENCE = 2'd2,
    MEM_CMD_AMO   = 2'd3
  } MemUnitCommand;

  typedef enum logic [1:0] {
    LS_CMD_BYTE   = 2'd0,
    LS_CMD_HALF   = 2'd1,
    LS_CMD_WORD   = 2'd2,
    LS_CMD_DOUBLE = 2'd3
  } LoadStoreUnitCommand;

  typedef struct packed {
    addr_t               addr;
    MemUnitCommand       command;
    LoadStoreUnitCommand loadStoreUnitCommand;
    word_t               imm;
    word_t               srcIntRegValue1;
    word_t               srcIntRegValue2;
    uint64_t             srcFpRegValue2;
    logic                invalidateTlb;
  } LsuRequest;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/load_store_arbiter_select.sv
// Combinational round-robin picker: the pointer names the preferred requester,
// a lone requester wins regardless of the pointer.
module load_store_arbiter_select
  import load_store_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_ptr,
  output logic               o_grant_valid_c,
  output logic               o_grant_idx_c
);

  always_comb begin
    o_grant_valid_c = |i_req;
    o_grant_idx_c   = 1'b0;
    if (i_req[i_ptr]) begin
      o_grant_idx_c = i_ptr;
    end else if (i_req[~i_ptr]) begin
      o_grant_idx_c = ~i_ptr;
    end
  end

endmodule

// File: rtl/load_store_arbiter.sv
// Arbitrates two requesters onto one shared load/store unit: IDLE picks a
// winner, BUSY drives the unit until done, RESP pulses the owner's reqDone.
module load_store_arbiter
  import load_store_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [NUM_REQ-1:0]    reqEnable,
  input  LsuRequest [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0]    reqDone,
  output logic [XLEN-1:0]       respResult,
  output logic                  respLoadPagefault,
  output logic                  respStorePagefault,
  output logic                  lsuEnable,
  output LsuRequest             lsuRequest,
  input  logic                  lsuDone,
  input  logic [XLEN-1:0]       lsuResult,
  input  logic                  lsuLoadPagefault,
  input  logic                  lsuStorePagefault,
  output logic                  busy
);

  state_t               r_state, w_next_state;
  logic                 r_ptr, w_ptr;
  logic                 r_owner, w_owner;
  LsuRequest            r_hold, w_hold;
  logic [XLEN-1:0]      r_result, w_result;
  logic                 r_lpf, w_lpf;
  logic                 r_spf, w_spf;
  logic [NUM_REQ-1:0]   r_req_done, w_req_done;
  logic                 r_lsu_enable, w_lsu_enable;
  logic                 r_busy, w_busy;
  logic                 w_grant_valid;
  logic                 w_grant_idx;

  load_store_arbiter_select u_select (
    .i_req           (reqEnable),
    .i_ptr           (r_ptr),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_idx_c   (w_grant_idx)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      r_hold       <= '0;
      r_result     <= '0;
      r_lpf        <= 1'b0;
      r_spf        <= 1'b0;
      r_req_done   <= '0;
      r_lsu_enable <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_ptr        <= w_ptr;
      r_owner      <= w_owner;
      r_hold       <= w_hold;
      r_result     <= w_result;
      r_lpf        <= w_lpf;
      r_spf        <= w_spf;
      r_req_done   <= w_req_done;
      r_lsu_enable <= w_lsu_enable;
      r_busy       <= w_busy;
    end
  end

  // Next state; output values are those of the state being entered
  always_comb begin
    w_next_state = r_state;
    w_ptr        = r_ptr;
    w_owner      = r_owner;
    w_hold       = r_hold;
    w_result     = r_result;
    w_lpf        = r_lpf;
    w_spf        = r_spf;
    w_req_done   = '0;
    w_lsu_enable = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_owner      = w_grant_idx;
          w_hold       = req[w_grant_idx];
          w_lsu_enable = 1'b1;
          w_busy       = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_busy = 1'b1;
        if (lsuDone) begin
          w_result            = lsuResult;
          w_lpf               = lsuLoadPagefault;
          w_spf               = lsuStorePagefault;
          w_req_done[r_owner] = 1'b1;
          w_next_state        = ST_RESP;
        end else begin
          w_lsu_enable = 1'b1;
        end
      end
      ST_RESP: begin
        w_ptr        = ~r_owner;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign reqDone            = r_req_done;
  assign respResult         = r_result;
  assign respLoadPagefault  = r_lpf;
  assign respStorePagefault = r_spf;
  assign lsuEnable          = r_lsu_enable;
  assign lsuRequest         = r_hold;
  assign busy               = r_busy;

endmodule

// File: tb/tb_load_store_arbiter.sv
// Scoreboard bench for load_store_arbiter: an LSU responder model predicts the
// winner and response, a monitor pops and compares on every reqDone.
module tb_load_store_arbiter;
  import load_store_arbiter_pkg::*;

  typedef struct {
    int          owner;
    logic [63:0] res;
    logic        lpf;
    logic        spf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic [1:0]       reqEnable = 2'b00;
  LsuRequest [1:0]  req = '0;
  logic [1:0]       reqDone;
  logic [63:0]      respResult;
  logic             respLoadPagefault;
  logic             respStorePagefault;
  logic             lsuEnable;
  LsuRequest        lsuRequest;
  logic             lsuDone;
  logic [63:0]      lsuResult = '0;
  logic             lsuLoadPagefault = 1'b0;
  logic             lsuStorePagefault = 1'b0;
  logic             busy;

  logic rsp_done = 1'b0;
  logic stray_done = 1'b0;
  assign lsuDone = rsp_done | stray_done;

  int n_cmp = 0;
  int n_fail = 0;

  // Responder knobs
  int          rsp_delay = -1;
  bit          rsp_fixed = 1'b0;
  logic [63:0] fix_res = '0;
  logic        fix_lpf = 1'b0;
  logic        fix_spf = 1'b0;

  exp_t q[$];
  int   done_cnt[2] = '{0, 0};

  load_store_arbiter dut (
    .clk                (clk),
    .rstN               (rstN),
    .reqEnable          (reqEnable),
    .req                (req),
    .reqDone            (reqDone),
    .respResult         (respResult),
    .respLoadPagefault  (respLoadPagefault),
    .respStorePagefault (respStorePagefault),
    .lsuEnable          (lsuEnable),
    .lsuRequest         (lsuRequest),
    .lsuDone            (lsuDone),
    .lsuResult          (lsuResult),
    .lsuLoadPagefault   (lsuLoadPagefault),
    .lsuStorePagefault  (lsuStorePagefault),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic LsuRequest rand_pay();
    LsuRequest p;
    p.addr                 = {$urandom, $urandom};
    p.command              = MemUnitCommand'(2'($urandom_range(3, 0)));
    p.loadStoreUnitCommand = LoadStoreUnitCommand'(2'($urandom_range(3, 0)));
    p.imm                  = {$urandom, $urandom};
    p.srcIntRegValue1      = {$urandom, $urandom};
    p.srcIntRegValue2      = {$urandom, $urandom};
    p.srcFpRegValue2       = {$urandom, $urandom};
    p.invalidateTlb        = 1'($urandom_range(1, 0));
    return p;
  endfunction

  // What the DUT saw at each rising edge
  logic [1:0]      pre_req = 2'b00;
  LsuRequest [1:0] pre_pay = '0;
  always @(posedge clk) begin
    pre_req = reqEnable;
    pre_pay = req;
  end

  // LSU responder plus transaction-level arbitration model
  bit        active = 1'b0;
  bit        prev_idle = 1'b1;
  bit        prev_done = 1'b0;
  logic      m_ptr = 1'b0;
  int        cnt = 0;
  int        exp_owner = 0;
  LsuRequest exp_pay = '0;
  always @(negedge clk) begin
    logic [63:0] r;
    logic        lp, sp;
    bit          idle_now, was_done;
    if (!rstN) begin
      active    = 1'b0;
      rsp_done  = 1'b0;
      prev_idle = 1'b1;
      prev_done = 1'b0;
      m_ptr     = 1'b0;
    end else begin
      was_done = rsp_done;
      if (rsp_done) begin
        rsp_done = 1'b0;
        chk(reqDone != 2'b00, "done_latency", 64'(reqDone), 64'(1));
        chk(!lsuEnable, "resp_lsuEnable", 64'(lsuEnable), 64'(0));
      end
      idle_now = prev_done || (prev_idle && pre_req == 2'b00);
      if (prev_idle && pre_req != 2'b00)
        chk(lsuEnable == 1'b1, "grant_latency", 64'(lsuEnable), 64'(1));
      if (idle_now)
        chk(!lsuEnable && !busy && reqDone == 2'b00, "idle_outputs", 64'({busy, lsuEnable, reqDone}), 64'(0));
      if (lsuEnable && !active && !was_done) begin
        chk(prev_idle && pre_req != 2'b00, "spurious_grant", 64'(pre_req), 64'(1));
        exp_owner = (pre_req == 2'b11) ? int'(m_ptr) : (pre_req[0] ? 0 : 1);
        exp_pay   = pre_pay[exp_owner];
        chk(lsuRequest == exp_pay, "grant_payload", lsuRequest.addr, exp_pay.addr);
        m_ptr  = (exp_owner == 0);
        active = 1'b1;
        cnt    = (rsp_delay < 0) ? int'($urandom_range(4, 0)) : rsp_delay;
      end
      if (active) begin
        chk(lsuEnable && lsuRequest == exp_pay, "busy_hold",
            {lsuEnable, lsuRequest.addr[62:0]}, {1'b1, exp_pay.addr[62:0]});
        if (cnt == 0) begin
          if (rsp_fixed) begin
            r = fix_res; lp = fix_lpf; sp = fix_spf;
          end else begin
            r  = {$urandom, $urandom};
            lp = ($urandom_range(7, 0) == 0);
            sp = ($urandom_range(7, 0) == 0);
          end
          lsuResult         = r;
          lsuLoadPagefault  = lp;
          lsuStorePagefault = sp;
          rsp_done          = 1'b1;
          q.push_back('{owner: exp_owner, res: r, lpf: lp, spf: sp});
          active = 1'b0;
        end else begin
          cnt--;
        end
      end
      prev_done = (reqDone != 2'b00);
      prev_idle = idle_now;
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT reports completion
  always @(negedge clk) begin
    exp_t e;
    if (rstN) begin
      chk(busy == (lsuEnable || reqDone != 2'b00), "busy_flag", 64'(busy), 64'(lsuEnable || reqDone != 2'b00));
      if (reqDone != 2'b00) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_reqDone", 64'(reqDone), 64'(0));
        end else begin
          e = q.pop_front();
          chk(reqDone == 2'(1 << e.owner), "reqDone_owner", 64'(reqDone), 64'(2'(1 << e.owner)));
          chk(respResult == e.res, "respResult", respResult, e.res);
          chk(respLoadPagefault == e.lpf, "respLoadPagefault", 64'(respLoadPagefault), 64'(e.lpf));
          chk(respStorePagefault == e.spf, "respStorePagefault", 64'(respStorePagefault), 64'(e.spf));
        end
        if (reqDone[0]) done_cnt[0]++;
        if (reqDone[1]) done_cnt[1]++;
      end
    end
  end

  task automatic wait_done(output logic [1:0] d);
    int w = 0;
    d = 2'b00;
    while (w < 200) begin
      @(negedge clk);
      w++;
      if (reqDone != 2'b00) begin
        d = reqDone;
        return;
      end
    end
    chk(1'b0, "timeout_reqDone", 64'(0), 64'(1));
  endtask

  task automatic drive(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      if (!reqEnable[i]) repeat ($urandom_range(4, 0)) @(negedge clk);
      req[i]       = rand_pay();
      reqEnable[i] = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!reqDone[i] && w < 300);
      if (w >= 300) chk(1'b0, "timeout_driver", 64'(i), 64'(1));
      if (k == n - 1 || $urandom_range(1, 0) == 0) reqEnable[i] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] d;
    logic [1:0] g[6];
    int         en_cnt, w, c0;
    LsuRequest  p;

    // Reset values
    @(negedge clk);
    chk(reqDone == 2'b00 && !lsuEnable && !busy, "reset_ctrl", 64'({reqDone, lsuEnable, busy}), 64'(0));
    chk(respResult == 64'd0 && !respLoadPagefault && !respStorePagefault, "reset_resp", respResult, 64'(0));
    chk(lsuRequest == LsuRequest'(0), "reset_hold", lsuRequest.addr, 64'(0));
    #2 rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester with fixed three-cycle LSU access
    rsp_delay = 2; rsp_fixed = 1'b1; fix_res = 64'hDEADBEEF; fix_lpf = 1'b0; fix_spf = 1'b0;
    p = '0; p.addr = 64'h1000; p.command = MEM_CMD_LOAD;
    req[0] = p; reqEnable = 2'b01;
    en_cnt = 0; d = 2'b00;
    for (int k = 0; k < 50 && d == 2'b00; k++) begin
      @(negedge clk);
      if (lsuEnable) en_cnt++;
      d = reqDone;
    end
    reqEnable = 2'b00;
    chk(d == 2'b01, "single_reqDone", 64'(d), 64'(1));
    chk(respResult == 64'hDEADBEEF, "single_result", respResult, 64'hDEADBEEF);
    chk(en_cnt == 3, "single_lsuEnable_cycles", 64'(en_cnt), 64'(3));
    rsp_fixed = 1'b0; rsp_delay = -1;
    repeat (3) @(negedge clk);

    // Contention straight out of reset
    #2 rstN = 1'b0;
    req[0] = rand_pay(); req[1] = rand_pay(); reqEnable = 2'b11;
    @(negedge clk);
    #2 rstN = 1'b1;
    wait_done(d);
    chk(d == 2'b01, "contention_first", 64'(d), 64'(1));
    reqEnable[0] = 1'b0;
    wait_done(d);
    chk(d == 2'b10, "contention_second", 64'(d), 64'(2));
    reqEnable[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Fairness with both requesters held high
    req[0] = rand_pay(); req[1] = rand_pay(); reqEnable = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_done(d);
      g[k] = d;
      if (k == 5) reqEnable = 2'b00;
      else if (d[0]) req[0] = rand_pay();
      else req[1] = rand_pay();
    end
    for (int k = 0; k < 6; k++)
      chk(g[k] == ((k % 2 == 0) ? 2'b01 : 2'b10), "fairness_order", 64'(g[k]), 64'((k % 2 == 0) ? 1 : 2));
    repeat (3) @(negedge clk);

    // Store fault on requester 1
    rsp_fixed = 1'b1; fix_res = 64'h0BAD_F00D; fix_lpf = 1'b0; fix_spf = 1'b1;
    p = rand_pay(); p.command = MEM_CMD_STORE;
    req[1] = p; reqEnable = 2'b10;
    wait_done(d);
    chk(d == 2'b10, "fault_reqDone", 64'(d), 64'(2));
    chk(respStorePagefault == 1'b1, "fault_store_flag", 64'(respStorePagefault), 64'(1));
    chk(respLoadPagefault == 1'b0, "fault_load_flag", 64'(respLoadPagefault), 64'(0));
    reqEnable = 2'b00; rsp_fixed = 1'b0;
    repeat (3) @(negedge clk);

    // Requester drops mid-access, then a stray lsuDone while idle
    rsp_delay = 3;
    c0 = done_cnt[0];
    req[0] = rand_pay(); reqEnable = 2'b01;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!lsuEnable && w < 50);
    chk(lsuEnable == 1'b1, "drop_grant", 64'(lsuEnable), 64'(1));
    @(negedge clk);
    reqEnable = 2'b00;
    wait_done(d);
    chk(d == 2'b01, "drop_reqDone", 64'(d), 64'(1));
    repeat (6) @(negedge clk);
    chk(done_cnt[0] - c0 == 1, "drop_single_pulse", 64'(done_cnt[0] - c0), 64'(1));
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    chk(!busy && !lsuEnable && reqDone == 2'b00, "stray_lsuDone_1", 64'({busy, lsuEnable, reqDone}), 64'(0));
    @(negedge clk);
    chk(!busy && !lsuEnable && reqDone == 2'b00, "stray_lsuDone_2", 64'({busy, lsuEnable, reqDone}), 64'(0));
    rsp_delay = -1;

    // Randomised traffic from both requesters
    fork
      drive(0, 15);
      drive(1, 15);
    join
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of an access
    rsp_delay = 20;
    c0 = done_cnt[0] + done_cnt[1];
    req[1] = rand_pay(); reqEnable = 2'b10;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!lsuEnable && w < 50);
    repeat (2) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    chk(reqDone == 2'b00 && !lsuEnable && !busy, "async_reset_ctrl", 64'({reqDone, lsuEnable, busy}), 64'(0));
    chk(respResult == 64'd0 && !respLoadPagefault && !respStorePagefault, "async_reset_resp", respResult, 64'(0));
    chk(lsuRequest == LsuRequest'(0), "async_reset_hold", lsuRequest.addr, 64'(0));
    reqEnable = 2'b00;
    @(negedge clk);
    #2 rstN = 1'b1;
    repeat (10) @(negedge clk);
    chk(done_cnt[0] + done_cnt[1] == c0, "reset_no_reqDone", 64'(done_cnt[0] + done_cnt[1] - c0), 64'(0));
    chk(q.size() == 0, "scoreboard_drained", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
